// File: rtl/sp_ram_fifo_ctrl.sv
// sp_ram_fifo_ctrl: FIFO controller in front of a single-port RAM with a
// one-cycle registered read. Turns push/pop handshakes into one RAM command
// per cycle. Simultaneous push and pop are arbitrated round-robin.
//
// Optional feature macro: SP_FIFO_ERR_FLAGS_EN
//   defined   -> err is a sticky flag for a push while full, or a pop
//                request while empty in IDLE
//   undefined -> err is tied low and illegal requests are silently ignored
//
// state     | meaning
// IDLE      | RAM port free; a push or a pop may be granted
// READ_WAIT | read issued last cycle; capture RAM data, pushes still allowed
module sp_ram_fifo_ctrl #(
    parameter int Data_Width = 8,
    parameter int Addr_Width = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_valid,
    input  logic [Data_Width-1:0] push_data,
    output logic                  push_ready,
    input  logic                  pop_req,
    output logic                  pop_ready,
    output logic [Data_Width-1:0] pop_data,
    output logic                  pop_valid,
    output logic [Addr_Width:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  err,
    output logic                  ram_wr_rd_ena,
    output logic [Addr_Width-1:0] ram_addr,
    output logic [Data_Width-1:0] ram_data_write,
    input  logic [Data_Width-1:0] ram_data_read
);

    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } state_t;

    localparam logic GRANT_PUSH = 1'b0;
    localparam logic GRANT_POP  = 1'b1;

    localparam logic [Addr_Width:0] Depth     = {1'b1, {Addr_Width{1'b0}}};
    localparam logic [Addr_Width:0] CountOne  = {{Addr_Width{1'b0}}, 1'b1};
    localparam logic [Addr_Width:0] CountLast = Depth - CountOne;

    state_t                state;
    logic                  last_grant;
    logic [Addr_Width-1:0] wr_ptr;
    logic [Addr_Width-1:0] rd_ptr;
    logic                  contend;
    logic                  pop_fire;
    logic                  push_fire;

    // Handshake arbitration and the RAM command for this cycle
    always_comb begin
        contend   = (state == IDLE) && push_valid && pop_req && !full && !empty;
        pop_ready = (state == IDLE) && !empty && !(contend && (last_grant == GRANT_POP));
        pop_fire  = pop_req && pop_ready;
        push_ready = !full && !pop_fire;
        push_fire  = push_valid && push_ready;

        ram_wr_rd_ena  = push_fire;
        ram_addr       = push_fire ? wr_ptr : rd_ptr;
        ram_data_write = push_fire ? push_data : '0;
    end

    // Pointers, occupancy, registered full/empty and round-robin memory
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            last_grant <= GRANT_POP;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
                count  <= count + CountOne;
                full   <= (count == CountLast);
                empty  <= 1'b0;
            end else if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - CountOne;
                empty  <= (count == CountOne);
                full   <= 1'b0;
            end
            if (contend) begin
                last_grant <= pop_fire ? GRANT_POP : GRANT_PUSH;
            end
        end
    end

    // Read sequencing FSM: wait out the RAM latency, then present the word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pop_data  <= '0;
            pop_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pop_valid <= 1'b0;
                    if (pop_fire) begin
                        state <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    pop_data  <= ram_data_read;
                    pop_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    pop_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef SP_FIFO_ERR_FLAGS_EN
    // Sticky record of any illegal request; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((push_valid && full) || ((state == IDLE) && pop_req && empty)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Bench for sp_ram_fifo_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
// A behavioural single-port RAM with registered read sits on the RAM port.
module tb_sp_ram_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       push_valid;
    logic [7:0] push_data;
    logic       push_ready;
    logic       pop_req;
    logic       pop_ready;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       err;
    logic       ram_wr_rd_ena;
    logic [1:0] ram_addr;
    logic [7:0] ram_data_write;
    logic [7:0] ram_data_read;

    sp_ram_fifo_ctrl #(.Data_Width(8), .Addr_Width(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_valid    (push_valid),
        .push_data     (push_data),
        .push_ready    (push_ready),
        .pop_req       (pop_req),
        .pop_ready     (pop_ready),
        .pop_data      (pop_data),
        .pop_valid     (pop_valid),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .err           (err),
        .ram_wr_rd_ena (ram_wr_rd_ena),
        .ram_addr      (ram_addr),
        .ram_data_write(ram_data_write),
        .ram_data_read (ram_data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: write at the edge, or registered read of the address
    logic [7:0] mem [4];
    always @(posedge clk) begin
        if (ram_wr_rd_ena) mem[ram_addr] <= ram_data_write;
        else               ram_data_read <= mem[ram_addr];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO contents as a queue plus read-in-flight tracking
    logic [7:0] q[$];
    logic       m_busy;
    logic [7:0] m_inflight;
    logic       m_pv;
    logic [7:0] m_pd;
    logic       m_err;
    logic       m_next_pop;
    int         m_wr_cnt;
    int         m_rd_cnt;
    int         n_push_f;
    int         n_pop_f;
    int         first_grant;

    task automatic model_clear();
        q.delete();
        m_busy = 1'b0; m_inflight = 8'h00; m_pv = 1'b0; m_pd = 8'h00;
        m_err = 1'b0; m_next_pop = 1'b0; m_wr_cnt = 0; m_rd_cnt = 0;
        n_push_f = 0; n_pop_f = 0; first_grant = -1;
    endtask

    task automatic do_reset(input bit check);
        rst_n = 1'b0; push_valid = 1'b0; pop_req = 1'b0; push_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        if (check) begin
            chk("rst_count", int'(count), 0);
            chk("rst_empty", int'(empty), 1);
            chk("rst_full", int'(full), 0);
            chk("rst_pop_valid", int'(pop_valid), 0);
            chk("rst_pop_data", int'(pop_data), 0);
            chk("rst_err", int'(err), 0);
            chk("rst_pop_ready", int'(pop_ready), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic pv, input logic [7:0] pd, input logic pr);
        logic fullm, emptym, contend, e_popr, e_popf, e_pushr, e_pushf;
        logic [1:0] e_addr;
        push_valid = pv; push_data = pd; pop_req = pr;
        @(negedge clk);
        fullm   = (q.size() == 4);
        emptym  = (q.size() == 0);
        contend = !m_busy && pv && pr && !fullm && !emptym;
        e_popr  = !m_busy && !emptym && !(contend && !m_next_pop);
        e_popf  = pr && e_popr;
        e_pushr = !fullm && !e_popf;
        e_pushf = pv && e_pushr;
        e_addr  = e_pushf ? 2'(m_wr_cnt) : 2'(m_rd_cnt);
        chk("push_ready", int'(push_ready), int'(e_pushr));
        chk("pop_ready", int'(pop_ready), int'(e_popr));
        chk("count", int'(count), q.size());
        chk("full", int'(full), int'(fullm));
        chk("empty", int'(empty), int'(emptym));
        chk("pop_valid", int'(pop_valid), int'(m_pv));
        chk("pop_data", int'(pop_data), int'(m_pd));
        chk("err", int'(err), int'(m_err));
        chk("ram_wr", int'(ram_wr_rd_ena), int'(e_pushf));
        chk("ram_addr", int'(ram_addr), int'(e_addr));
        chk("ram_wdata", int'(ram_data_write), e_pushf ? int'(pd) : 0);
        @(posedge clk);
`ifdef SP_FIFO_ERR_FLAGS_EN
        if ((pv && fullm) || (pr && emptym && !m_busy)) m_err = 1'b1;
`endif
        if (contend) begin
            m_next_pop = e_pushf;
            if (first_grant < 0) first_grant = e_pushf ? 0 : 1;
        end
        if (e_pushf) begin
            q.push_back(pd);
            m_wr_cnt++;
            n_push_f++;
        end
        if (m_busy) begin
            m_pv = 1'b1; m_pd = m_inflight; m_busy = 1'b0;
        end else begin
            m_pv = 1'b0;
        end
        if (e_popf) begin
            m_inflight = q.pop_front();
            m_busy = 1'b1;
            m_rd_cnt++;
            n_pop_f++;
        end
        #1;
    endtask

    typedef struct {
        logic       pv;
        logic [7:0] pd;
        logic       pr;
        logic       e_pushr;
        logic       e_popr;
        logic       e_wr;
        logic [1:0] e_addr;
        logic [2:0] e_cnt;
        logic       e_pv;
        logic [7:0] e_pd;
    } vec_t;

    vec_t tbl[15];

    initial begin
        bit ok;
        rst_n = 1'b0; push_valid = 1'b0; pop_req = 1'b0; push_data = 8'h00;

        //           pv    pd     pr    pushr popr  wr    addr  cnt   pv_o  pd_o
        tbl[0]  = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 3'd1, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 3'd2, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 3'd3, 1'b0, 8'h00};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd4, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd4, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 3'd3, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 3'd3, 1'b1, 8'h06};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 3'd2, 1'b0, 8'h06};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 3'd2, 1'b1, 8'h05};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 3'd1, 1'b0, 8'h05};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 3'd1, 1'b1, 8'h04};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h04};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'h03};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h03};

        // Fill to full, then drain: directed vectors
        do_reset(1'b1);
        for (int i = 0; i < 15; i++) begin
            push_valid = tbl[i].pv; push_data = tbl[i].pd; pop_req = tbl[i].pr;
            @(negedge clk);
            chk("tbl_push_ready", int'(push_ready), int'(tbl[i].e_pushr));
            chk("tbl_pop_ready", int'(pop_ready), int'(tbl[i].e_popr));
            chk("tbl_ram_wr", int'(ram_wr_rd_ena), int'(tbl[i].e_wr));
            chk("tbl_ram_addr", int'(ram_addr), int'(tbl[i].e_addr));
            chk("tbl_count", int'(count), int'(tbl[i].e_cnt));
            chk("tbl_full", int'(full), int'(tbl[i].e_cnt == 3'd4));
            chk("tbl_empty", int'(empty), int'(tbl[i].e_cnt == 3'd0));
            chk("tbl_pop_valid", int'(pop_valid), int'(tbl[i].e_pv));
            chk("tbl_pop_data", int'(pop_data), int'(tbl[i].e_pd));
            chk("tbl_err", int'(err), 0);
            @(posedge clk);
            #1;
        end

        // Write pointer wraps 3->0; order preserved across the wrap
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h20 + 8'(i), 1'b0);
        chk("wrap_count", q.size(), 4);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, (q.size() != 0) ? 1'b1 : 1'b0);
        chk("wrap_drained", int'(empty), 1);

        // Push and pop held together from count 2: alternation, no starvation
        do_reset(1'b0);
        step(1'b1, 8'hA0, 1'b0);
        step(1'b1, 8'hA1, 1'b0);
        n_push_f = 0; n_pop_f = 0;
        for (int i = 0; i < 12; i++) step(1'b1, 8'(8'hB0 + i), 1'b1);
        chk("contend_first_is_push", first_grant, 0);
        ok = (n_push_f >= 3) && (n_pop_f >= 3);
        chk("contend_no_starve", int'(ok), 1);

        // Reset during READ_WAIT discards the in-flight read
        do_reset(1'b0);
        step(1'b1, 8'hAA, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("midrd_count", int'(count), 0);
        chk("midrd_pop_valid", int'(pop_valid), 0);
        chk("midrd_empty", int'(empty), 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        chk("midrd_pop_data", int'(pop_data), 0);

        // Pop request on empty: err is sticky when the flag feature is built
        do_reset(1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h55, 1'b0);
`ifdef SP_FIFO_ERR_FLAGS_EN
        chk("err_sticky", int'(err), 1);
`else
        chk("err_tied_low", int'(err), 0);
`endif

        // Randomized traffic against the reference model
        do_reset(1'b0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0, 8'($urandom),
                 ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
